uart_tx_arbiter: RTL

Shares one UART_TX instance among NUM_REQ byte-stream requesters. Arbitration is round-robin at byte granularity. The block latches the winner's byte and parity mode, drives tx_start/d_in/parity into UART_TX, and waits for the tx_get_data acknowledge. It also generates the 16x-oversampling b_tick that UART_TX consumes, and flags a lost acknowledge with a timeout.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side blocks: parity mode encodings,
// arbiter state encodings and the default baud divider.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Parity mode encodings as understood by UART_TX (passed through untouched).
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    // clk cycles per 16x-oversampling tick.
    localparam int DEFAULT_BAUD_DIV = 16;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running baud tick generator. A counter runs 0..BAUD_DIV-1 and wraps;
// b_tick is high for the single cycle in which the counter sits at its top
// value. Shared between the UART transmit and receive paths.
//
// Ports:
//   clk       in   system clock
//   a_resetn  in   asynchronous active-low reset (counter -> 0)
//   b_tick    out  one-cycle pulse every BAUD_DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic a_resetn,
    output logic b_tick
);

    localparam int             CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Decoded from the counter so the pulse is 0 while in reset and the first
    // tick is seen by consumers on the BAUD_DIV-th edge after release.
    assign b_tick = (cnt_reg == LAST);

endmodule : uart_baud_gen

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART_TX among NUM_REQ byte-stream requesters with byte-granular
// round-robin arbitration. The winning byte and parity mode are latched and
// presented to UART_TX with tx_start until tx_get_data acknowledges them, or
// until ACK_TIMEOUT baud ticks pass, in which case the byte is dropped and a
// sticky error is raised. Also provides the baud tick UART_TX runs from.
//
// Ports:
//   clk, a_resetn  clock, asynchronous active-low reset
//   enable         1 = new grants allowed (an in-flight byte always completes)
//   req_valid      per-requester byte pending
//   req_data       byte i at [8i+7:8i]
//   req_parity     parity mode i at [2i+1:2i]
//   req_ready      one-cycle pulse: byte i accepted
//   b_tick         baud tick to UART_TX
//   tx_start       request to UART_TX
//   d_in, parity   latched byte / parity mode to UART_TX
//   tx_get_data    one-cycle acknowledge from UART_TX
//   busy           arbiter not idle
//   grant_id       index of the last/current grant
//   err_timeout    sticky acknowledge-timeout flag
//   err_clr        clears err_timeout (a simultaneous timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       a_resetn,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [2*NUM_REQ-1:0]       req_parity,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       b_tick,
    output logic                       tx_start,
    output logic [7:0]                 d_in,
    output logic [1:0]                 parity,
    input  logic                       tx_get_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout,
    input  logic                       err_clr
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam int            TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]     grant_id_reg, grant_id_next;
    logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
    logic              tx_start_reg, tx_start_next;
    logic [7:0]        d_in_reg, d_in_next;
    logic [1:0]        parity_reg, parity_next;
    logic              err_timeout_reg, err_timeout_next;
    logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic              set_err;

    logic [7:0]        data_arr [NUM_REQ];
    logic [1:0]        par_arr  [NUM_REQ];

    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;

    // ------------------------------------------------------------------
    // Baud tick
    // ------------------------------------------------------------------
    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .a_resetn (a_resetn),
        .b_tick   (b_tick)
    );

    // ------------------------------------------------------------------
    // Split the flat request buses into per-requester lanes
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign data_arr[gi] = req_data[8*gi +: 8];
            assign par_arr[gi]  = req_parity[2*gi +: 2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    // The modulo keeps the scan correct for non-power-of-two NUM_REQ.
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IW'((int'(rr_ptr_reg) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        req_ready_next = '0;
        tx_start_next  = tx_start_reg;
        d_in_next      = d_in_reg;
        parity_next    = parity_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        set_err        = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (enable && found) begin
                    d_in_next         = data_arr[pick];
                    parity_next       = par_arr[pick];
                    grant_id_next     = pick;
                    req_ready_next[pick] = 1'b1;
                    rr_ptr_next       = IW'((int'(pick) + 1) % NUM_REQ);
                    state_next        = ST_LOAD;
                end
            end

            ST_LOAD: begin
                tx_start_next = 1'b1;
                tmo_cnt_next  = '0;
                state_next    = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                // Acknowledge has priority over a coincident timeout tick.
                if (tx_get_data) begin
                    tx_start_next = 1'b0;
                    state_next    = ST_IDLE;
                end else if (b_tick) begin
                    if (tmo_cnt_reg == TMO_LAST) begin
                        tx_start_next = 1'b0;
                        set_err       = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                tx_start_next = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase

        // Set beats clear.
        if (set_err) begin
            err_timeout_next = 1'b1;
        end else if (err_clr) begin
            err_timeout_next = 1'b0;
        end else begin
            err_timeout_next = err_timeout_reg;
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            req_ready_reg   <= '0;
            tx_start_reg    <= 1'b0;
            d_in_reg        <= '0;
            parity_reg      <= PAR_NONE;
            err_timeout_reg <= 1'b0;
            tmo_cnt_reg     <= '0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            grant_id_reg    <= grant_id_next;
            req_ready_reg   <= req_ready_next;
            tx_start_reg    <= tx_start_next;
            d_in_reg        <= d_in_next;
            parity_reg      <= parity_next;
            err_timeout_reg <= err_timeout_next;
            tmo_cnt_reg     <= tmo_cnt_next;
        end
    end

    assign req_ready   = req_ready_reg;
    assign tx_start    = tx_start_reg;
    assign d_in        = d_in_reg;
    assign parity      = parity_reg;
    assign grant_id    = grant_id_reg;
    assign err_timeout = err_timeout_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule : uart_tx_arbiter
